// File: rtl/avl_dual_port_arbiter.sv
// rtl/avl_dual_port_arbiter.sv - two-master round-robin arbiter for a UniPHY Avalon-MM local port
module avl_dual_port_arbiter #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 384,
    parameter int BE_W   = 48,
    parameter int MAX_RD = 8
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iINIT_DONE,
    input  logic [ADDR_W-1:0]           m0_address,
    input  logic [DATA_W-1:0]           m0_writedata,
    input  logic [BE_W-1:0]             m0_byteenable,
    input  logic                        m0_read,
    input  logic                        m0_write,
    output logic                        m0_waitrequest_n,
    output logic [DATA_W-1:0]           m0_readdata,
    output logic                        m0_readdatavalid,
    input  logic [ADDR_W-1:0]           m1_address,
    input  logic [DATA_W-1:0]           m1_writedata,
    input  logic [BE_W-1:0]             m1_byteenable,
    input  logic                        m1_read,
    input  logic                        m1_write,
    output logic                        m1_waitrequest_n,
    output logic [DATA_W-1:0]           m1_readdata,
    output logic                        m1_readdatavalid,
    input  logic                        avl_ready,
    output logic [ADDR_W-1:0]           avl_addr,
    output logic [DATA_W-1:0]           avl_wdata,
    output logic [BE_W-1:0]             avl_be,
    output logic                        avl_read_req,
    output logic                        avl_write_req,
    output logic                        avl_burstbegin,
    output logic [2:0]                  avl_size,
    input  logic                        avl_rdata_valid,
    input  logic [DATA_W-1:0]           avl_rdata,
    output logic [$clog2(MAX_RD):0]     oRD_PENDING,
    output logic                        oERR
);
    localparam int PTR_W = $clog2(MAX_RD);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

    state_t             state;
    logic               last_served;
    logic [MAX_RD-1:0]  tag_mem;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   tag_count;
    logic               err_q;
    logic               tag_full, tag_empty, tag_head;
    logic               req0, req1, sel_read, sel_write;
    logic               accept, push, pop;

    // Tie goes to the master that was not served last.
    function automatic state_t next_grant(input logic init_done, input logic r0,
                                          input logic r1, input logic ls);
        state_t nxt;
        nxt = IDLE;
        if (init_done) begin
            if (r0 && r1)
                nxt = ls ? GRANT0 : GRANT1;
            else if (r0)
                nxt = GRANT0;
            else if (r1)
                nxt = GRANT1;
        end
        return nxt;
    endfunction

    assign tag_full  = (tag_count == CNT_W'(MAX_RD));
    assign tag_empty = (tag_count == '0);
    assign tag_head  = tag_mem[rd_ptr];

    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        avl_addr  = '0;
        avl_wdata = '0;
        avl_be    = '0;
        case (state)
            GRANT0: begin
                sel_read  = m0_read;
                sel_write = m0_write;
                avl_addr  = m0_address;
                avl_wdata = m0_writedata;
                avl_be    = m0_byteenable;
            end
            GRANT1: begin
                sel_read  = m1_read;
                sel_write = m1_write;
                avl_addr  = m1_address;
                avl_wdata = m1_writedata;
                avl_be    = m1_byteenable;
            end
            default: ;
        endcase
        // A reader with no free tag is held off; writes never need a tag.
        avl_read_req     = sel_read & ~tag_full;
        avl_write_req    = sel_write;
        avl_burstbegin   = avl_read_req | avl_write_req;
        accept           = (avl_read_req | avl_write_req) & avl_ready;
        push             = accept & avl_read_req;
        pop              = avl_rdata_valid & ~tag_empty;
        m0_waitrequest_n = (state == GRANT0) & avl_ready & ~(m0_read & tag_full);
        m1_waitrequest_n = (state == GRANT1) & avl_ready & ~(m1_read & tag_full);
        m0_readdatavalid = pop & ~tag_head;
        m1_readdatavalid = pop & tag_head;
    end

    assign m0_readdata = avl_rdata;
    assign m1_readdata = avl_rdata;
    assign avl_size    = 3'b001;
    assign oRD_PENDING = tag_count;
    assign oERR        = err_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= IDLE;
            last_served <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_count   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: ;
            endcase
            if (avl_rdata_valid && tag_empty)
                err_q <= 1'b1;
            // A presented command is never withdrawn; re-arbitrate on acceptance or when X goes quiet.
            case (state)
                IDLE: state <= next_grant(iINIT_DONE, req0, req1, last_served);
                GRANT0: begin
                    if (accept) begin
                        last_served <= 1'b0;
                        state       <= next_grant(iINIT_DONE, req0, req1, 1'b0);
                    end else if (!req0) begin
                        state <= next_grant(iINIT_DONE, req0, req1, last_served);
                    end
                end
                GRANT1: begin
                    if (accept) begin
                        last_served <= 1'b1;
                        state       <= next_grant(iINIT_DONE, req0, req1, 1'b1);
                    end else if (!req1) begin
                        state <= next_grant(iINIT_DONE, req0, req1, last_served);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (push)
            tag_mem[wr_ptr] <= (state == GRANT1);
    end
endmodule

// File: tb/tb_avl_dual_port_arbiter.sv
// tb/tb_avl_dual_port_arbiter.sv - directed self-checking bench for avl_dual_port_arbiter
module tb_avl_dual_port_arbiter;
    localparam int AW = 23;
    localparam int DW = 384;
    localparam int BW = 48;
    localparam int MR = 8;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iINIT_DONE = 1'b0;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [BW-1:0] m0_byteenable = '1, m1_byteenable = '1;
    logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic          m0_waitrequest_n, m1_waitrequest_n;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          avl_ready = 1'b1;
    logic [AW-1:0] avl_addr;
    logic [DW-1:0] avl_wdata;
    logic [BW-1:0] avl_be;
    logic          avl_read_req, avl_write_req, avl_burstbegin;
    logic [2:0]    avl_size;
    logic          avl_rdata_valid = 1'b0;
    logic [DW-1:0] avl_rdata = '0;
    logic [$clog2(MR):0] oRD_PENDING;
    logic          oERR;

    int checks = 0;
    int passed = 0;

    avl_dual_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_RD(MR)) dut (
        .iCLK(iCLK), .iRST(iRST), .iINIT_DONE(iINIT_DONE),
        .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_waitrequest_n(m0_waitrequest_n),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest_n(m1_waitrequest_n),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .avl_ready(avl_ready), .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
        .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
        .avl_burstbegin(avl_burstbegin), .avl_size(avl_size),
        .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
        .oRD_PENDING(oRD_PENDING), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_masters();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        avl_rdata_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        clear_masters();
        iRST = 1'b1;
        #1;
        chk("rst_pending", 64'(oRD_PENDING), 64'd0);
        chk("rst_err", 64'(oERR), 64'd0);
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    // Entered at a negedge; holds the strobe until accepted, returns at a negedge with it dropped.
    task automatic issue(input int m, input logic rd, input logic [AW-1:0] a, input string tag);
        logic ok;
        ok = 1'b0;
        if (m == 0) begin m0_address = a; m0_read = rd; m0_write = ~rd; end
        else        begin m1_address = a; m1_read = rd; m1_write = ~rd; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((m == 0) ? m0_waitrequest_n : m1_waitrequest_n) begin
                ok = 1'b1;
                break;
            end
            @(negedge iCLK);
        end
        chk(tag, 64'(ok), 64'd1);
        @(negedge iCLK);
        if (m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
        else        begin m1_read = 1'b0; m1_write = 1'b0; end
    endtask

    initial begin
        logic ok;
        // Reset state
        @(negedge iCLK);
        @(negedge iCLK);
        #1;
        chk("rst_rd_req", 64'(avl_read_req), 64'd0);
        chk("rst_wr_req", 64'(avl_write_req), 64'd0);
        chk("rst_wrn", 64'({m1_waitrequest_n, m0_waitrequest_n}), 64'd0);
        chk("rst_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'd0);
        chk("rst_pending", 64'(oRD_PENDING), 64'd0);
        chk("rst_err", 64'(oERR), 64'd0);
        chk("avl_size", 64'(avl_size), 64'd1);
        @(negedge iCLK);
        iRST = 1'b0;

        // Calibration gating
        m0_address = 23'h5;
        m0_write   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("init_gate", 64'(avl_write_req), 64'd0);
            @(negedge iCLK);
        end
        iINIT_DONE = 1'b1;
        #1;
        chk("init_lat0", 64'(avl_write_req), 64'd0);
        @(negedge iCLK);
        #1;
        chk("init_wr", 64'(avl_write_req), 64'd1);
        chk("init_wrn0", 64'(m0_waitrequest_n), 64'd1);
        chk("init_addr", 64'(avl_addr), 64'h5);
        @(negedge iCLK);
        m0_write = 1'b0;

        // Both writing continuously: strict alternation starting with m0
        do_reset();
        m0_address = 23'h100; m0_write = 1'b1;
        m1_address = 23'h200; m1_write = 1'b1;
        #1;
        chk("alt_idle", 64'(avl_write_req), 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge iCLK);
            #1;
            chk("alt_grant", 64'({avl_write_req, m1_waitrequest_n, m0_waitrequest_n}),
                (k % 2 == 0) ? 64'b101 : 64'b110);
            chk("alt_addr", 64'(avl_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
        end
        @(negedge iCLK);
        clear_masters();

        // avl_ready stall while GRANT1
        do_reset();
        avl_ready  = 1'b0;
        m1_address = 23'h33; m1_write = 1'b1;
        @(negedge iCLK);
        m0_address = 23'h44; m0_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_wr", 64'(avl_write_req), 64'd1);
            chk("stall_addr", 64'(avl_addr), 64'h33);
            chk("stall_wrn", 64'({m1_waitrequest_n, m0_waitrequest_n}), 64'd0);
            @(negedge iCLK);
        end
        avl_ready = 1'b1;
        #1;
        chk("stall_acc", 64'({m1_waitrequest_n, m0_waitrequest_n}), 64'b10);
        chk("stall_acc_addr", 64'(avl_addr), 64'h33);
        @(negedge iCLK);
        m1_write = 1'b0;
        #1;
        chk("stall_next", 64'({m1_waitrequest_n, m0_waitrequest_n}), 64'b01);
        chk("stall_next_addr", 64'(avl_addr), 64'h44);
        @(negedge iCLK);
        clear_masters();

        // Read steering by tag order
        do_reset();
        issue(0, 1'b1, 23'hA, "rd_a");
        issue(1, 1'b1, 23'hB, "rd_b");
        issue(0, 1'b1, 23'hC, "rd_c");
        #1;
        chk("rd_pending3", 64'(oRD_PENDING), 64'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            avl_rdata_valid = 1'b1;
            avl_rdata       = DW'(i + 1);
            #1;
            chk("rd_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), (i == 1) ? 64'b10 : 64'b01);
            chk("rd_data", 64'(m0_readdata), 64'(i + 1));
        end
        @(negedge iCLK);
        avl_rdata_valid = 1'b0;
        #1;
        chk("rd_pending0", 64'(oRD_PENDING), 64'd0);
        chk("rd_err", 64'(oERR), 64'd0);

        // Tag FIFO full stall
        do_reset();
        for (int i = 0; i < MR; i++)
            issue(0, 1'b1, AW'(i), "full_fill");
        #1;
        chk("full_pending8", 64'(oRD_PENDING), 64'd8);
        @(negedge iCLK);
        m0_address = 23'h99; m0_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_stall", 64'({avl_read_req, m0_waitrequest_n}), 64'd0);
            @(negedge iCLK);
        end
        avl_rdata_valid = 1'b1;
        avl_rdata       = DW'(16'h77);
        #1;
        chk("full_pop_rdv", 64'(m0_readdatavalid), 64'd1);
        @(negedge iCLK);
        avl_rdata_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (m0_waitrequest_n && avl_read_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge iCLK);
        end
        chk("full_unblock", 64'(ok), 64'd1);
        @(negedge iCLK);
        m0_read = 1'b0;
        #1;
        chk("full_pending_end", 64'(oRD_PENDING), 64'd8);

        // Reset discards tags; stray return data flags oERR
        do_reset();
        avl_rdata_valid = 1'b1;
        #1;
        chk("err_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'd0);
        @(negedge iCLK);
        avl_rdata_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("err_sticky", 64'(oERR), 64'd1);
            @(negedge iCLK);
        end
        do_reset();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
